// File: rtl/tawas_rf_wb_arb_if.sv
// AXI load-return and register-file write-back signals of the write-back arbiter.
// The slave modport is the arbiter's view; the master modport is the bus/register-file side.
interface tawas_rf_wb_arb_if;
    logic        RSP_VLD;
    logic        RSP_RDY;
    logic [1:0]  RSP_SLICE;
    logic [2:0]  RSP_SEL;
    logic [31:0] RSP_DATA;
    logic        AXI_LOAD_VLD;
    logic [1:0]  AXI_LOAD_SLICE;
    logic [2:0]  AXI_LOAD_SEL;
    logic [31:0] AXI_LOAD;

    modport slave (
        input  RSP_VLD, RSP_SLICE, RSP_SEL, RSP_DATA,
        output RSP_RDY, AXI_LOAD_VLD, AXI_LOAD_SLICE, AXI_LOAD_SEL, AXI_LOAD
    );

    modport master (
        output RSP_VLD, RSP_SLICE, RSP_SEL, RSP_DATA,
        input  RSP_RDY, AXI_LOAD_VLD, AXI_LOAD_SLICE, AXI_LOAD_SEL, AXI_LOAD
    );
endinterface

// File: rtl/tawas_rf_wb_arb.sv
// Register-file AXI load write-back arbiter: FIFOs load returns and retires them only in
// cycles without a colliding pipeline write. TAWAS_RF_WB_SCOREBOARD_EN adds the PENDING output.
module tawas_rf_wb_arb #(
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int STALL_WARN = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       SLICE,
    input  logic             PC_STORE,
    input  logic             RF_IMM_VLD,
    input  logic [2:0]       RF_IMM_SEL,
    input  logic             AU_RC_VLD,
    input  logic [2:0]       AU_RC_SEL,
    input  logic             LS_PTR_UPD_VLD,
    input  logic [2:0]       LS_PTR_UPD_SEL,
    input  logic             LS_LOAD_VLD,
    input  logic [2:0]       LS_LOAD_SEL,
    tawas_rf_wb_arb_if.slave wb,
    output logic [PTR_W:0]   FIFO_CNT,
    output logic             STALL_WARN_P
`ifdef TAWAS_RF_WB_SCOREBOARD_EN
    ,
    output logic [31:0]      PENDING
`endif
);

    logic [1:0]       mem_slice [DEPTH];
    logic [2:0]       mem_sel   [DEPTH];
    logic [31:0]      mem_data  [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [7:0]       stall_cnt;
    logic [7:0]       stall_nxt;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             hit;
    logic             conflict;
    logic [4:0]       head_tgt;
    logic [1:0]       slice_m1;
    logic [1:0]       slice_p1;
    logic [1:0]       slice_p2;

    assign empty    = (FIFO_CNT == '0);
    assign full     = (FIFO_CNT == (PTR_W+1)'(DEPTH));
    assign push     = wb.RSP_VLD && !full;
    assign pop      = wb.AXI_LOAD_VLD;
    assign head_tgt = {mem_slice[rd_ptr], mem_sel[rd_ptr]};
    assign slice_m1 = SLICE - 2'd1;
    assign slice_p1 = SLICE + 2'd1;
    assign slice_p2 = SLICE + 2'd2;

    always_comb begin
        hit = 1'b0;
        if (PC_STORE       && head_tgt == {slice_m1, 3'd6})           hit = 1'b1;
        if (RF_IMM_VLD     && head_tgt == {slice_m1, RF_IMM_SEL})     hit = 1'b1;
        if (AU_RC_VLD      && head_tgt == {slice_p1, AU_RC_SEL})      hit = 1'b1;
        if (LS_PTR_UPD_VLD && head_tgt == {slice_p2, LS_PTR_UPD_SEL}) hit = 1'b1;
        if (LS_LOAD_VLD    && head_tgt == {SLICE, LS_LOAD_SEL})       hit = 1'b1;
    end

    assign conflict          = !empty && hit;
    assign wb.RSP_RDY        = !full;
    assign wb.AXI_LOAD_VLD   = !empty && !conflict;
    assign wb.AXI_LOAD_SLICE = mem_slice[rd_ptr];
    assign wb.AXI_LOAD_SEL   = mem_sel[rd_ptr];
    assign wb.AXI_LOAD       = mem_data[rd_ptr];

    // Stall count clears whenever the head is not blocked (popped or FIFO empty).
    always_comb begin
        stall_nxt = '0;
        if (conflict) stall_nxt = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_slice[wr_ptr] <= wb.RSP_SLICE;
            mem_sel[wr_ptr]   <= wb.RSP_SEL;
            mem_data[wr_ptr]  <= wb.RSP_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            FIFO_CNT     <= '0;
            stall_cnt    <= '0;
            STALL_WARN_P <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   FIFO_CNT <= FIFO_CNT + 1'b1;
                2'b01:   FIFO_CNT <= FIFO_CNT - 1'b1;
                default: FIFO_CNT <= FIFO_CNT;
            endcase
            stall_cnt    <= stall_nxt;
            STALL_WARN_P <= (stall_nxt == 8'(STALL_WARN)) && (stall_cnt != 8'(STALL_WARN));
        end
    end

`ifdef TAWAS_RF_WB_SCOREBOARD_EN
    logic [PTR_W-1:0] pend_idx;

    always_comb begin
        PENDING  = '0;
        pend_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_idx = rd_ptr + PTR_W'(i);
            if ((PTR_W+1)'(i) < FIFO_CNT)
                PENDING[{mem_slice[pend_idx], mem_sel[pend_idx]}] = 1'b1;
        end
    end
`endif

endmodule
